br_update_ctrl: RTL and testbench

BR_UPDATE_CTRL -- requirements
Module: br_update_ctrl

---
 rtl/bp_pkg.sv | 29 ++
 rtl/br_upd_fifo.sv | 60 ++++++
 rtl/br_update_ctrl.sv | 136 +++++++++++++
 tb/tb_br_update_ctrl.sv | 496 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared branch-predictor definitions: branch-type encodings, controller
// state codes, default predictor index width and the update payload layout.
package bp_pkg;

  // Default predictor index width; a flush sweep visits 2**BP_IDX_W entries.
  localparam int BP_IDX_W = 6;

  // Branch-type encodings carried with every update.
  localparam logic [1:0] BR_PLAIN = 2'd0;
  localparam logic [1:0] BR_CALL  = 2'd1;
  localparam logic [1:0] BR_RET   = 2'd2;

  // Update-controller states.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_SWEEP = 2'd2;

  // One resolved-branch update as it travels through the update FIFO.
  typedef struct packed {
    logic        mispredict;
    logic        taken;
    logic [63:0] br_pc;
    logic [63:0] target_next_pc;
    logic [1:0]  br_type;
  } br_upd_t;

  localparam int BR_UPD_W = $bits(br_upd_t);

endpackage

// File: rtl/br_upd_fifo.sv
// Update FIFO between the execute stage and the predictor update port.
// Pointers wrap modulo DEPTH (power of two); a separate occupancy count
// gives full/empty. The head entry is readable combinationally.
module br_upd_fifo
  import bp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = BR_UPD_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int             PW       = $clog2(DEPTH);
  localparam logic [PW:0]    FULL_CNT = (PW + 1)'(DEPTH);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic [W-1:0]  mem [DEPTH];
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; reset discards all queued entries.
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage write port.
  always_ff @(posedge clock) begin
    // NOTE: storage is not reset; the count decides validity, so stale data is never observed.
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/br_update_ctrl.sv
// Branch predictor update controller. Queues resolved branches from execute
// and streams them to the predictor one per cycle; on a fence.i request it
// drains the queue and then sweeps every predictor entry with an invalidate.
// Optional build macro BR_UPD_STATS_EN adds saturating update/mispredict
// counters on io_stat_upd / io_stat_mis.
module br_update_ctrl
  import bp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IDX_W = BP_IDX_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_ex_valid,
  output logic             io_ex_ready,
  input  logic             io_ex_mispredict,
  input  logic             io_ex_taken,
  input  logic [63:0]      io_ex_br_pc,
  input  logic [63:0]      io_ex_target_next_pc,
  input  logic [1:0]       io_ex_br_type,
  input  logic             io_flush_req,
  output logic             io_flush_busy,
  output logic             io_flush_done,
  output logic             io_pred_stall,
  output logic             io_br_info_valid,
  output logic             io_br_info_mispredict,
  output logic             io_br_info_taken,
  output logic [63:0]      io_br_info_br_pc,
  output logic [63:0]      io_br_info_target_next_pc,
  output logic [1:0]       io_br_info_br_type,
  output logic             io_br_info_inv,
  output logic [IDX_W-1:0] io_br_info_inv_index
`ifdef BR_UPD_STATS_EN
  ,
  output logic [31:0]      io_stat_upd,
  output logic [31:0]      io_stat_mis
`endif
);

  localparam logic [IDX_W-1:0] LAST_IDX = {IDX_W{1'b1}};

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [IDX_W-1:0] sweep_idx_q;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             sweep_last;
  br_upd_t          wr_upd;
  br_upd_t          rd_upd;
  br_upd_t          out_upd;

  // New updates are only taken while idle; a flush closes the door until the sweep ends.
  assign io_ex_ready = !fifo_full && (state_q == ST_IDLE);
  assign push        = io_ex_valid && io_ex_ready;
  assign pop         = !fifo_empty && ((state_q == ST_IDLE) || (state_q == ST_DRAIN));

  assign wr_upd = '{mispredict:     io_ex_mispredict,
                    taken:          io_ex_taken,
                    br_pc:          io_ex_br_pc,
                    target_next_pc: io_ex_target_next_pc,
                    br_type:        io_ex_br_type};

  br_upd_fifo #(
    .DEPTH (DEPTH),
    .W     (BR_UPD_W)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (wr_upd),
    .rdata (rd_upd),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // The head entry is presented in the cycle it pops; payload is zeroed otherwise.
  assign out_upd                   = pop ? rd_upd : '0;
  assign io_br_info_valid          = pop;
  assign io_br_info_mispredict     = out_upd.mispredict;
  assign io_br_info_taken          = out_upd.taken;
  assign io_br_info_br_pc          = out_upd.br_pc;
  assign io_br_info_target_next_pc = out_upd.target_next_pc;
  assign io_br_info_br_type        = out_upd.br_type;

  // Sweep never overlaps an update because popping is disabled in SWEEP.
  assign sweep_last           = (state_q == ST_SWEEP) && (sweep_idx_q == LAST_IDX);
  assign io_br_info_inv       = (state_q == ST_SWEEP);
  assign io_br_info_inv_index = sweep_idx_q;
  assign io_pred_stall        = (state_q == ST_SWEEP);
  assign io_flush_busy        = (state_q != ST_IDLE);
  assign io_flush_done        = sweep_last;

  // Next-state logic; flush requests outside IDLE are simply dropped.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (io_flush_req) state_d = ST_DRAIN;
      ST_DRAIN: if (fifo_empty)   state_d = ST_SWEEP;
      ST_SWEEP: if (sweep_last)   state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  // State register and sweep index; the index rewinds to 0 on the last entry.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      sweep_idx_q <= '0;
    end else begin
      state_q <= state_d;
      if (sweep_last) begin
        sweep_idx_q <= '0;
      end else if (state_q == ST_SWEEP) begin
        sweep_idx_q <= sweep_idx_q + 1'b1;
      end
    end
  end

`ifdef BR_UPD_STATS_EN
  // Saturating counters of delivered updates and of mispredicted ones.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      io_stat_upd <= '0;
      io_stat_mis <= '0;
    end else if (pop) begin
      if (io_stat_upd != '1) io_stat_upd <= io_stat_upd + 32'd1;
      if (rd_upd.mispredict && (io_stat_mis != '1)) io_stat_mis <= io_stat_mis + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_br_update_ctrl.sv
// Self-checking bench for br_update_ctrl. A cycle-level reference model built
// from a queue of pending updates plus a phase/sweep counter predicts every
// output each cycle; scenario tasks add targeted checks on top.
module tb_br_update_ctrl;
  import bp_pkg::*;

  localparam int DEPTH = 4;
  localparam int IDX_W = 6;
  localparam int NENT  = 1 << IDX_W;

  localparam int PH_IDLE  = 0;
  localparam int PH_DRAIN = 1;
  localparam int PH_SWEEP = 2;

  logic             clock;
  logic             reset;
  logic             io_ex_valid;
  logic             io_ex_ready;
  logic             io_ex_mispredict;
  logic             io_ex_taken;
  logic [63:0]      io_ex_br_pc;
  logic [63:0]      io_ex_target_next_pc;
  logic [1:0]       io_ex_br_type;
  logic             io_flush_req;
  logic             io_flush_busy;
  logic             io_flush_done;
  logic             io_pred_stall;
  logic             io_br_info_valid;
  logic             io_br_info_mispredict;
  logic             io_br_info_taken;
  logic [63:0]      io_br_info_br_pc;
  logic [63:0]      io_br_info_target_next_pc;
  logic [1:0]       io_br_info_br_type;
  logic             io_br_info_inv;
  logic [IDX_W-1:0] io_br_info_inv_index;
`ifdef BR_UPD_STATS_EN
  logic [31:0]      io_stat_upd;
  logic [31:0]      io_stat_mis;
`endif

  br_update_ctrl #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clock                     (clock),
    .reset                     (reset),
    .io_ex_valid               (io_ex_valid),
    .io_ex_ready               (io_ex_ready),
    .io_ex_mispredict          (io_ex_mispredict),
    .io_ex_taken               (io_ex_taken),
    .io_ex_br_pc               (io_ex_br_pc),
    .io_ex_target_next_pc      (io_ex_target_next_pc),
    .io_ex_br_type             (io_ex_br_type),
    .io_flush_req              (io_flush_req),
    .io_flush_busy             (io_flush_busy),
    .io_flush_done             (io_flush_done),
    .io_pred_stall             (io_pred_stall),
    .io_br_info_valid          (io_br_info_valid),
    .io_br_info_mispredict     (io_br_info_mispredict),
    .io_br_info_taken          (io_br_info_taken),
    .io_br_info_br_pc          (io_br_info_br_pc),
    .io_br_info_target_next_pc (io_br_info_target_next_pc),
    .io_br_info_br_type        (io_br_info_br_type),
    .io_br_info_inv            (io_br_info_inv),
    .io_br_info_inv_index      (io_br_info_inv_index)
`ifdef BR_UPD_STATS_EN
    ,
    .io_stat_upd               (io_stat_upd),
    .io_stat_mis               (io_stat_mis)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic        mis;
    logic        tk;
    logic [63:0] pc;
    logic [63:0] tgt;
    logic [1:0]  ty;
  } upd_t;

  // Snapshot of every observable output in one cycle.
  typedef struct packed {
    logic             ready;
    logic             valid;
    logic             mis;
    logic             tk;
    logic [63:0]      pc;
    logic [63:0]      tgt;
    logic [1:0]       ty;
    logic             inv;
    logic [IDX_W-1:0] idx;
    logic             busy;
    logic             stall;
    logic             done;
  } snap_t;

  int    n_tests = 0;
  int    n_fail  = 0;

  // Reference model state.
  upd_t        q[$];
  int          m_phase;
  int          m_sweep;
  logic [31:0] m_upd;
  logic [31:0] m_mis;

  // Per-cycle observation results of the latest step.
  snap_t obs;
  snap_t exp;
  int    n_inv, n_done, n_valid, n_drain;

  const upd_t IDLE_U = '0;

  function automatic snap_t sample();
    snap_t s;
    s.ready = io_ex_ready;
    s.valid = io_br_info_valid;
    s.mis   = io_br_info_mispredict;
    s.tk    = io_br_info_taken;
    s.pc    = io_br_info_br_pc;
    s.tgt   = io_br_info_target_next_pc;
    s.ty    = io_br_info_br_type;
    s.inv   = io_br_info_inv;
    s.idx   = io_br_info_inv_index;
    s.busy  = io_flush_busy;
    s.stall = io_pred_stall;
    s.done  = io_flush_done;
    return s;
  endfunction

  function automatic upd_t rand_upd();
    upd_t u;
    u.mis = 1'($urandom_range(1));
    u.tk  = 1'($urandom_range(1));
    u.pc  = {$urandom, $urandom};
    u.tgt = {$urandom, $urandom};
    u.ty  = 2'($urandom_range(2));
    return u;
  endfunction

  task automatic model_reset();
    q.delete();
    m_phase = PH_IDLE;
    m_sweep = 0;
    m_upd   = '0;
    m_mis   = '0;
  endtask

  task automatic clear_obs();
    n_inv = 0; n_done = 0; n_valid = 0; n_drain = 0;
  endtask

  // Drive one cycle of stimulus, capture DUT outputs and model predictions,
  // then advance the model across the clock edge. Entered and left at posedge+1.
  task automatic step(input bit v, input upd_t u, input bit fl);
    bit   was_empty;
    upd_t h;
    io_ex_valid          = v;
    io_ex_mispredict     = u.mis;
    io_ex_taken          = u.tk;
    io_ex_br_pc          = u.pc;
    io_ex_target_next_pc = u.tgt;
    io_ex_br_type        = u.ty;
    io_flush_req         = fl;
    #1;
    obs = sample();
    exp = '0;
    exp.ready = (m_phase == PH_IDLE) && (q.size() < DEPTH);
    if (m_phase != PH_SWEEP && q.size() > 0) begin
      exp.valid = 1'b1;
      exp.mis   = q[0].mis;
      exp.tk    = q[0].tk;
      exp.pc    = q[0].pc;
      exp.tgt   = q[0].tgt;
      exp.ty    = q[0].ty;
    end
    exp.inv   = (m_phase == PH_SWEEP);
    exp.idx   = (m_phase == PH_SWEEP) ? IDX_W'(m_sweep) : '0;
    exp.busy  = (m_phase != PH_IDLE);
    exp.stall = (m_phase == PH_SWEEP);
    exp.done  = (m_phase == PH_SWEEP) && (m_sweep == NENT - 1);
    if (obs.inv)                n_inv++;
    if (obs.done)               n_done++;
    if (obs.valid)              n_valid++;
    if (obs.busy && !obs.stall) n_drain++;
    @(posedge clock);
    was_empty = (q.size() == 0);
    if (exp.valid) begin
      h = q.pop_front();
      if (m_upd != 32'hFFFF_FFFF) m_upd = m_upd + 32'd1;
      if (h.mis && m_mis != 32'hFFFF_FFFF) m_mis = m_mis + 32'd1;
    end
    if (v && exp.ready) q.push_back(u);
    case (m_phase)
      PH_IDLE:  if (fl) m_phase = PH_DRAIN;
      PH_DRAIN: if (was_empty) m_phase = PH_SWEEP;
      default: begin
        if (m_sweep == NENT - 1) begin
          m_phase = PH_IDLE;
          m_sweep = 0;
        end else begin
          m_sweep++;
        end
      end
    endcase
    #1;
    io_ex_valid  = 1'b0;
    io_flush_req = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    model_reset();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    snap_t want;
    reset                = 1'b0;
    io_ex_valid          = 1'b0;
    io_ex_mispredict     = 1'b0;
    io_ex_taken          = 1'b0;
    io_ex_br_pc          = '0;
    io_ex_target_next_pc = '0;
    io_ex_br_type        = BR_PLAIN;
    io_flush_req         = 1'b0;
    model_reset();
    #3;
    want       = '0;
    want.ready = 1'b1;
    obs        = sample();
    n_tests++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want %h", obs, want);
    end
`ifdef BR_UPD_STATS_EN
    n_tests++;
    if (io_stat_upd !== 32'd0 || io_stat_mis !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_stats: got upd=%h mis=%h want 0/0", io_stat_upd, io_stat_mis);
    end
`endif
    #4;
    reset = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic test_single_update();
    upd_t u;
    u.mis = 1'b1;
    u.tk  = 1'b1;
    u.pc  = 64'h8000_0010;
    u.tgt = 64'h8000_0100;
    u.ty  = BR_CALL;
    step(1'b1, u, 1'b0);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL single_push_cycle: got %h want %h", obs, exp);
    end
    step(1'b0, IDLE_U, 1'b0);
    n_tests++;
    if (obs.valid !== 1'b1 || obs.pc !== 64'h8000_0010 || obs.tgt !== 64'h8000_0100 ||
        obs.mis !== 1'b1 || obs.tk !== 1'b1 || obs.ty !== BR_CALL) begin
      n_fail++;
      $display("FAIL single_update_payload: got v=%b pc=%h tgt=%h mis=%b tk=%b ty=%0d want v=1 pc=80000010 tgt=80000100 mis=1 tk=1 ty=1",
               obs.valid, obs.pc, obs.tgt, obs.mis, obs.tk, obs.ty);
    end
    step(1'b0, IDLE_U, 1'b0);
    n_tests++;
    if (obs.valid !== 1'b0 || obs.pc !== 64'd0) begin
      n_fail++;
      $display("FAIL single_update_after: got v=%b pc=%h want v=0 pc=0", obs.valid, obs.pc);
    end
  endtask

  task automatic test_back_pressure();
    logic [63:0] got[$];
    logic [63:0] sent[$];
    upd_t        u;
    for (int i = 0; i < 5; i++) begin
      u    = rand_upd();
      u.pc = 64'h1000 + 64'(i * 4);
      sent.push_back(u.pc);
      step(1'b1, u, 1'b0);
      if (obs.valid) got.push_back(obs.pc);
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL back_pressure_cycle%0d: got %h want %h", i, obs, exp);
      end
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, IDLE_U, 1'b0);
      if (obs.valid) got.push_back(obs.pc);
    end
    n_tests++;
    if (got.size() != 5) begin
      n_fail++;
      $display("FAIL back_pressure_count: got %0d updates want 5", got.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_tests++;
        if (got[i] !== sent[i]) begin
          n_fail++;
          $display("FAIL back_pressure_order%0d: got %h want %h", i, got[i], sent[i]);
        end
      end
    end
  endtask

  task automatic test_flush_pending();
    int cyc;
    clear_obs();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, rand_upd(), 1'b0);
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL flush_pending_push%0d: got %h want %h", i, obs, exp);
      end
    end
    step(1'b0, IDLE_U, 1'b1);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL flush_pending_req: got %h want %h", obs, exp);
    end
    cyc = 0;
    while (n_done == 0 && cyc < 200) begin
      step(1'b0, IDLE_U, 1'b0);
      cyc++;
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL flush_pending_cyc%0d: got %h want %h", cyc, obs, exp);
      end
    end
    n_tests++;
    if (n_done != 1 || n_inv != NENT || n_valid != 3) begin
      n_fail++;
      $display("FAIL flush_pending_totals: got done=%0d inv=%0d upd=%0d want 1/%0d/3", n_done, n_inv, n_valid, NENT);
    end
    step(1'b0, IDLE_U, 1'b0);
    n_tests++;
    if (obs.busy !== 1'b0 || obs.inv !== 1'b0 || obs.ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_pending_idle: got busy=%b inv=%b ready=%b want 0/0/1", obs.busy, obs.inv, obs.ready);
    end
  endtask

  task automatic test_flush_empty();
    int cyc;
    bit fl;
    clear_obs();
    step(1'b0, IDLE_U, 1'b1);
    cyc = 0;
    while (n_done == 0 && cyc < 200) begin
      fl = obs.inv && (obs.idx == IDX_W'(29));
      step(1'b0, IDLE_U, fl);
      cyc++;
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL flush_empty_cyc%0d: got %h want %h", cyc, obs, exp);
      end
    end
    for (int i = 0; i < 70; i++) begin
      step(1'b0, IDLE_U, 1'b0);
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL flush_empty_tail%0d: got %h want %h", i, obs, exp);
      end
    end
    n_tests++;
    if (n_drain != 1 || n_inv != NENT || n_done != 1) begin
      n_fail++;
      $display("FAIL flush_empty_totals: got drain=%0d inv=%0d done=%0d want 1/%0d/1", n_drain, n_inv, n_done, NENT);
    end
  endtask

  task automatic test_reset_sweep();
    int    cyc;
    snap_t s;
    step(1'b1, rand_upd(), 1'b1);
    cyc = 0;
    while (!(m_phase == PH_SWEEP && m_sweep == 20) && cyc < 200) begin
      step(1'b0, IDLE_U, 1'b0);
      cyc++;
    end
    #1;
    s = sample();
    n_tests++;
    if (s.inv !== 1'b1 || s.idx !== IDX_W'(20)) begin
      n_fail++;
      $display("FAIL reset_sweep_reach: got inv=%b idx=%0d want inv=1 idx=20", s.inv, s.idx);
    end
    reset = 1'b0;
    #1;
    s = sample();
    n_tests++;
    if (s.inv !== 1'b0 || s.ready !== 1'b1 || s.busy !== 1'b0 || s.valid !== 1'b0 ||
        s.idx !== '0 || s.stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_sweep_async: got inv=%b ready=%b busy=%b valid=%b idx=%0d stall=%b want 0/1/0/0/0/0",
               s.inv, s.ready, s.busy, s.valid, s.idx, s.stall);
    end
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    @(posedge clock);
    #1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, IDLE_U, 1'b0);
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL reset_sweep_after%0d: got %h want %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_random();
    bit v;
    bit fl;
    for (int i = 0; i < 400; i++) begin
      v  = ($urandom_range(3) != 0);
      fl = ($urandom_range(59) == 0);
      step(v, rand_upd(), fl);
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL random_cyc%0d: got %h want %h", i, obs, exp);
      end
    end
  endtask

`ifdef BR_UPD_STATS_EN
  task automatic test_stats();
    upd_t u;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      u     = rand_upd();
      u.mis = (i < 4);
      step(1'b1, u, 1'b0);
    end
    step(1'b0, IDLE_U, 1'b0);
    step(1'b0, IDLE_U, 1'b0);
    n_tests++;
    if (io_stat_upd !== m_upd || io_stat_mis !== m_mis || m_upd != 32'd10 || m_mis != 32'd4) begin
      n_fail++;
      $display("FAIL stats_counts: got upd=%0d mis=%0d want %0d/%0d", io_stat_upd, io_stat_mis, m_upd, m_mis);
    end
    force dut.io_stat_upd = 32'hFFFF_FFFF;
    #1;
    release dut.io_stat_upd;
    m_upd = 32'hFFFF_FFFF;
    step(1'b1, rand_upd(), 1'b0);
    step(1'b0, IDLE_U, 1'b0);
    step(1'b0, IDLE_U, 1'b0);
    n_tests++;
    if (io_stat_upd !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL stats_saturate: got %h want ffffffff", io_stat_upd);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_update();
    test_back_pressure();
    test_flush_pending();
    test_flush_empty();
    test_reset_sweep();
    test_random();
`ifdef BR_UPD_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
